// File: rtl/canny_stage_sequencer_if.sv
// Handshake bundle between the frame host, the stage datapaths
// and the canny stage sequencer.
interface canny_stage_sequencer_if #(
    parameter int NUM_STAGES = 6,
    parameter int CNT_W      = 32
);
    logic                  start;
    logic                  abort;
    logic                  clear_error;
    logic [NUM_STAGES-1:0] stage_done;
    logic [NUM_STAGES-1:0] stage_enable;
    logic                  busy;
    logic                  frame_done;
    logic                  error;
    logic [2:0]            error_stage;
    logic [CNT_W-1:0]      frame_cycles;

    modport master (
        output start,
        output abort,
        output clear_error,
        output stage_done,
        input  stage_enable,
        input  busy,
        input  frame_done,
        input  error,
        input  error_stage,
        input  frame_cycles
    );

    modport slave (
        input  start,
        input  abort,
        input  clear_error,
        input  stage_done,
        output stage_enable,
        output busy,
        output frame_done,
        output error,
        output error_stage,
        output frame_cycles
    );
endinterface

// File: rtl/canny_stage_sequencer.sv
// Frame controller: runs the edge-detection stages one at a time with
// a per-stage watchdog, abort, error capture and frame cycle count.
module canny_stage_sequencer #(
    parameter int NUM_STAGES     = 6,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int CNT_W          = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    canny_stage_sequencer_if.slave bus
);

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_MAX =
        WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit WD_ON = (TIMEOUT_CYCLES != 0);
    localparam logic [2:0] LAST_IDX = 3'(NUM_STAGES - 1);
    localparam logic [NUM_STAGES-1:0] EN_ONE = NUM_STAGES'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_GAP,
        S_DONE,
        S_ERROR
    } state_e;

    state_e                state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      fcyc_q, fcyc_d;
    logic [2:0]            esg_q, esg_d;
    logic [NUM_STAGES-1:0] en_q, en_d;
    logic                  busy_q, busy_d;
    logic                  fdone_q, fdone_d;
    logic                  err_q, err_d;

    logic done_act;
    logic wd_expired;
    logic cnt_sat;
    logic in_frame;

    // en_q is one-hot on the active stage only in RUN, so it masks done
    assign done_act   = |(bus.stage_done & en_q);
    assign wd_expired = WD_ON && (wd_q == WD_MAX);
    assign cnt_sat    = &cnt_q;
    assign in_frame   = (state_q == S_RUN) || (state_q == S_GAP);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wd_d    = wd_q;
        cnt_d   = cnt_q;
        fcyc_d  = fcyc_q;
        esg_d   = esg_q;

        if (in_frame && !cnt_sat) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                    wd_d    = '0;
                    cnt_d   = '0;
                    esg_d   = '0;
                end
            end
            S_RUN: begin
                if (done_act) begin
                    state_d = (idx_q == LAST_IDX) ? S_DONE : S_GAP;
                end else if (wd_expired) begin
                    state_d = S_ERROR;
                    esg_d   = idx_q;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_GAP: begin
                state_d = S_RUN;
                idx_d   = idx_q + 3'd1;
                wd_d    = '0;
            end
            S_DONE: begin
                state_d = S_IDLE;
                fcyc_d  = cnt_sat ? cnt_q : cnt_q + CNT_W'(1);
            end
            S_ERROR: begin
                if (bus.clear_error) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // abort overrides everything and leaves the captured results alone
        if (bus.abort) begin
            state_d = S_IDLE;
            idx_d   = '0;
            wd_d    = wd_q;
            cnt_d   = cnt_q;
            fcyc_d  = fcyc_q;
            esg_d   = esg_q;
        end

        en_d    = (state_d == S_RUN) ? (EN_ONE << idx_d) : '0;
        busy_d  = (state_d == S_RUN) || (state_d == S_GAP) ||
                  (state_d == S_DONE);
        fdone_d = (state_d == S_DONE);
        err_d   = (state_d == S_ERROR);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wd_q    <= '0;
            cnt_q   <= '0;
            fcyc_q  <= '0;
            esg_q   <= '0;
            en_q    <= '0;
            busy_q  <= 1'b0;
            fdone_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wd_q    <= wd_d;
            cnt_q   <= cnt_d;
            fcyc_q  <= fcyc_d;
            esg_q   <= esg_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            fdone_q <= fdone_d;
            err_q   <= err_d;
        end
    end

    assign bus.stage_enable = en_q;
    assign bus.busy         = busy_q;
    assign bus.frame_done   = fdone_q;
    assign bus.error        = err_q;
    assign bus.error_stage  = esg_q;
    assign bus.frame_cycles = fcyc_q;

endmodule

// File: tb/tb_canny_stage_sequencer.sv
// Randomized bench for canny_stage_sequencer against a schedule model
// derived from per-stage done latencies.
module tb_canny_stage_sequencer;

    localparam int NS = 6;
    localparam int TO = 16;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    canny_stage_sequencer_if #(.NUM_STAGES(NS), .CNT_W(CW)) bus ();

    canny_stage_sequencer #(
        .NUM_STAGES(NS),
        .TIMEOUT_CYCLES(TO),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave)
    );

    int n_tests = 0;
    int n_fail = 0;
    int lat[NS];
    logic [CW-1:0] last_fc = '0;
    logic [11:0] obs;

    assign obs = {bus.stage_enable, bus.busy, bus.frame_done,
                  bus.error, bus.error_stage};

    // Stage i is enabled for lat[i]+1 cycles, done on its last one,
    // then one idle gap; cycle 1 is the first cycle after start accept.
    function automatic void model(input int c,
                                  output logic [NS-1:0] en,
                                  output logic [NS-1:0] dn,
                                  output logic [NS-1:0] gd,
                                  output logic bsy,
                                  output logic fd);
        int t;
        en = '0;
        dn = '0;
        gd = '0;
        t = 1;
        for (int i = 0; i < NS; i++) begin
            if (c >= t && c <= t + lat[i]) begin
                en[i] = 1'b1;
                if (c == t + lat[i]) dn[i] = 1'b1;
            end
            if (c >= t - 1 && c <= t + lat[i]) gd[i] = 1'b1;
            t += lat[i] + 2;
        end
        bsy = (c >= 1) && (c <= t - 1);
        fd = (c == t - 1);
    endfunction

    function automatic int exp_cycles();
        int s = 0;
        for (int i = 0; i < NS; i++) s += lat[i] + 1;
        return s + (NS - 1) + 1;
    endfunction

    function automatic int stage_start(input int k);
        int t = 1;
        for (int i = 0; i < k; i++) t += lat[i] + 2;
        return t;
    endfunction

    task automatic rand_lat(input int lo, input int hi);
        for (int i = 0; i < NS; i++) lat[i] = $urandom_range(hi, lo);
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.clear_error = 1'b0;
        bus.stage_done = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if (obs !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_outs obs=%b want=%b", obs, 12'h0);
        end
        n_tests++;
        if (bus.frame_cycles !== '0) begin
            n_fail++;
            $display("FAIL reset_fc got=%0d want=0", bus.frame_cycles);
        end
        reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (obs !== 12'h0) begin
            n_fail++;
            $display("FAIL post_reset obs=%b want=%b", obs, 12'h0);
        end
    endtask

    task automatic test_fixed_latency();
        logic [NS-1:0] en, dn, gd;
        logic bsy, fd;
        int nfd = 0;
        int last;
        for (int i = 0; i < NS; i++) lat[i] = 3;
        last = exp_cycles() + 2;
        bus.start = 1'b1;
        for (int c = 1; c <= last; c++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            model(c, en, dn, gd, bsy, fd);
            bus.stage_done = dn;
            @(negedge clk);
            if (bus.frame_done === 1'b1) nfd++;
            n_tests++;
            if (obs !== {en, bsy, fd, 1'b0, 3'd0}) begin
                n_fail++;
                $display("FAIL fixed c=%0d obs=%b want=%b",
                         c, obs, {en, bsy, fd, 1'b0, 3'd0});
            end
        end
        bus.stage_done = '0;
        n_tests++;
        if (bus.frame_cycles !== 32'd30) begin
            n_fail++;
            $display("FAIL fixed_fc got=%0d want=30", bus.frame_cycles);
        end
        n_tests++;
        if (nfd != 1) begin
            n_fail++;
            $display("FAIL fixed_fd_count got=%0d want=1", nfd);
        end
        last_fc = 32'd30;
    endtask

    task automatic test_all_done();
        logic [NS-1:0] en, dn, gd;
        logic bsy, fd;
        int fd_at = -1;
        for (int i = 0; i < NS; i++) lat[i] = 0;
        bus.stage_done = 6'h3F;
        @(negedge clk);
        bus.start = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            model(c, en, dn, gd, bsy, fd);
            @(negedge clk);
            if (bus.frame_done === 1'b1 && fd_at < 0) fd_at = c;
            n_tests++;
            if (!$onehot0(bus.stage_enable) ||
                obs !== {en, bsy, fd, 1'b0, 3'd0}) begin
                n_fail++;
                $display("FAIL all_done c=%0d obs=%b want=%b",
                         c, obs, {en, bsy, fd, 1'b0, 3'd0});
            end
        end
        bus.stage_done = '0;
        n_tests++;
        if (fd_at != 12) begin
            n_fail++;
            $display("FAIL all_done_fd_cycle got=%0d want=12", fd_at);
        end
        n_tests++;
        if (bus.frame_cycles !== 32'd12) begin
            n_fail++;
            $display("FAIL all_done_fc got=%0d want=12", bus.frame_cycles);
        end
        last_fc = 32'd12;
    endtask

    task automatic run_frame(input string name, input bit noisy);
        logic [NS-1:0] en, dn, gd;
        logic bsy, fd;
        int dc;
        dc = exp_cycles();
        @(negedge clk);
        bus.start = 1'b1;
        for (int c = 1; c <= dc + 2; c++) begin
            @(posedge clk);
            #1;
            model(c, en, dn, gd, bsy, fd);
            bus.start = noisy && (c % 3 == 0) && (c <= dc);
            bus.stage_done = dn;
            if (noisy) begin
                bus.stage_done = dn | (NS'($urandom) & ~gd);
                if (en[1]) bus.stage_done[5] = 1'b1;
            end
            @(negedge clk);
            n_tests++;
            if (obs !== {en, bsy, fd, 1'b0, 3'd0}) begin
                n_fail++;
                $display("FAIL %s c=%0d obs=%b want=%b",
                         name, c, obs, {en, bsy, fd, 1'b0, 3'd0});
            end
        end
        idle_inputs();
        last_fc = CW'(dc);
        n_tests++;
        if (bus.frame_cycles !== last_fc) begin
            n_fail++;
            $display("FAIL %s_fc got=%0d want=%0d",
                     name, bus.frame_cycles, last_fc);
        end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 4; f++) begin
            rand_lat(0, 6);
            run_frame("random", 1'b0);
        end
    endtask

    task automatic test_spurious();
        for (int f = 0; f < 3; f++) begin
            rand_lat(1, 6);
            run_frame("spurious", 1'b1);
        end
    endtask

    task automatic test_done_wins();
        rand_lat(0, 3);
        lat[0] = TO - 1;
        lat[3] = TO - 1;
        run_frame("done_wins", 1'b0);
    endtask

    task automatic test_timeout();
        logic [NS-1:0] en, dn, gd;
        logic bsy, fd;
        logic [11:0] want;
        int t2;
        rand_lat(0, 4);
        lat[2] = 1000;
        t2 = stage_start(2);
        @(negedge clk);
        bus.start = 1'b1;
        for (int c = 1; c <= t2 + TO + 6; c++) begin
            @(posedge clk);
            #1;
            model(c, en, dn, gd, bsy, fd);
            bus.stage_done = dn;
            bus.start = (c == 1) ? 1'b0 : (c == t2 + TO + 2);
            bus.clear_error = (c == t2 + TO + 4);
            @(negedge clk);
            if (c <= t2 + TO - 1) want = {en, bsy, fd, 1'b0, 3'd0};
            else if (c <= t2 + TO + 4) want = {6'd0, 3'b001, 3'd2};
            else want = {6'd0, 3'b000, 3'd2};
            n_tests++;
            if (obs !== want) begin
                n_fail++;
                $display("FAIL timeout c=%0d obs=%b want=%b", c, obs, want);
            end
        end
        idle_inputs();
        n_tests++;
        if (bus.frame_cycles !== last_fc) begin
            n_fail++;
            $display("FAIL timeout_fc got=%0d want=%0d",
                     bus.frame_cycles, last_fc);
        end
    endtask

    task automatic test_abort();
        logic [NS-1:0] en, dn, gd;
        logic bsy, fd;
        logic [11:0] want;
        int ta;
        int nfd = 0;
        rand_lat(0, 4);
        ta = stage_start(3) + lat[3];
        @(negedge clk);
        bus.start = 1'b1;
        for (int c = 1; c <= ta + 6; c++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            model(c, en, dn, gd, bsy, fd);
            bus.stage_done = dn;
            bus.abort = (c == ta);
            @(negedge clk);
            if (bus.frame_done === 1'b1) nfd++;
            want = (c <= ta) ? {en, bsy, fd, 1'b0, 3'd0} : 12'h0;
            n_tests++;
            if (obs !== want) begin
                n_fail++;
                $display("FAIL abort c=%0d obs=%b want=%b", c, obs, want);
            end
        end
        idle_inputs();
        n_tests++;
        if (nfd != 0 || bus.frame_cycles !== last_fc) begin
            n_fail++;
            $display("FAIL abort_result fd=%0d fc=%0d want fd=0 fc=%0d",
                     nfd, bus.frame_cycles, last_fc);
        end
    endtask

    task automatic test_abort_error();
        logic [NS-1:0] en, dn, gd;
        logic bsy, fd;
        logic [11:0] want;
        for (int i = 0; i < NS; i++) lat[i] = 1000;
        @(negedge clk);
        bus.start = 1'b1;
        for (int c = 1; c <= TO + 4; c++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            model(c, en, dn, gd, bsy, fd);
            bus.abort = (c == TO + 2);
            @(negedge clk);
            if (c <= TO) want = {en, bsy, fd, 1'b0, 3'd0};
            else if (c <= TO + 2) want = {6'd0, 3'b001, 3'd0};
            else want = 12'h0;
            n_tests++;
            if (obs !== want) begin
                n_fail++;
                $display("FAIL abort_err c=%0d obs=%b want=%b",
                         c, obs, want);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_gap();
        logic [NS-1:0] en, dn, gd;
        logic bsy, fd;
        int tg;
        rand_lat(0, 4);
        tg = stage_start(1) - 1;
        @(negedge clk);
        bus.start = 1'b1;
        for (int c = 1; c <= tg; c++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            model(c, en, dn, gd, bsy, fd);
            bus.stage_done = dn;
            @(negedge clk);
            n_tests++;
            if (obs !== {en, bsy, fd, 1'b0, 3'd0}) begin
                n_fail++;
                $display("FAIL pre_reset c=%0d obs=%b want=%b",
                         c, obs, {en, bsy, fd, 1'b0, 3'd0});
            end
        end
        #1;
        reset_n = 1'b0;
        idle_inputs();
        #1;
        n_tests++;
        if (obs !== 12'h0 || bus.frame_cycles !== '0) begin
            n_fail++;
            $display("FAIL async_reset obs=%b fc=%0d want obs=0 fc=0",
                     obs, bus.frame_cycles);
        end
        @(negedge clk);
        reset_n = 1'b1;
        last_fc = '0;
        rand_lat(0, 4);
        run_frame("after_reset", 1'b0);
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fixed_latency();
        test_all_done();
        test_random_frames();
        test_spurious();
        test_done_wins();
        test_timeout();
        test_abort();
        test_abort_error();
        test_reset_gap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
